// File: rtl/gshare_predictor_if.sv
// Request/result handshake between fetch/resolve logic and the gshare predictor.
// The master drives requests and resolved-branch results; the slave returns predictions and status.
interface gshare_predictor_if #(
   parameter int unsigned PC_W   = 32,
   parameter int unsigned IDX_W  = 8,
   parameter int unsigned HIST_W = 8,
   parameter int unsigned CNT_W  = 16
) ();
   logic              ready;
   logic              request;
   logic [PC_W-1:0]   pc;
   logic              pred_valid;
   logic              prediction;
   logic [IDX_W-1:0]  pred_idx;
   logic              result;
   logic [IDX_W-1:0]  upd_idx;
   logic              taken;
   logic              upd_pred;
   logic [HIST_W-1:0] ghr;
   logic [CNT_W-1:0]  mispredicts;

   modport master (
      output request, pc, result, upd_idx, taken, upd_pred,
      input  ready, pred_valid, prediction, pred_idx, ghr, mispredicts
   );

   modport slave (
      input  request, pc, result, upd_idx, taken, upd_pred,
      output ready, pred_valid, prediction, pred_idx, ghr, mispredicts
   );
endinterface

// File: rtl/gshare_predictor.sv
// PC-indexed table of saturating counters, optionally XORed with global history (gshare).
// Sweeps the table to weakly-not-taken after reset, then serves predictions and updates.
module gshare_predictor #(
   parameter int unsigned PC_W     = 32,
   parameter int unsigned PC_SHIFT = 2,
   parameter int unsigned IDX_W    = 8,
   parameter int unsigned HIST_W   = 8,
   parameter int unsigned CTR_W    = 2,
   parameter int unsigned MODE     = 1,
   parameter int unsigned CNT_W    = 16
) (
   input logic               clk,
   input logic               rst,
   gshare_predictor_if.slave bus
);

   localparam int unsigned      DEPTH   = 2 ** IDX_W;
   localparam logic [CTR_W-1:0] WNT     = CTR_W'((2 ** (CTR_W - 1)) - 1);
   localparam logic [CTR_W-1:0] CTR_MAX = '1;

   typedef enum logic {INIT, RUN} state_t;

   state_t            state;
   logic [IDX_W-1:0]  ptr;
   logic              ready_q;
   logic              pred_valid_q;
   logic              prediction_q;
   logic [IDX_W-1:0]  pred_idx_q;
   logic [HIST_W-1:0] ghr_q;
   logic [CNT_W-1:0]  mis_q;

   logic [CTR_W-1:0]  table_q [DEPTH];
   logic [IDX_W-1:0]  base;
   logic [IDX_W-1:0]  idx;
   logic [CTR_W-1:0]  upd_ctr;
   logic [CTR_W-1:0]  upd_next;
   logic              unused_pc;

   assign base      = bus.pc[PC_SHIFT +: IDX_W];
   assign idx       = (MODE != 0) ? (base ^ IDX_W'(ghr_q)) : base;
   assign unused_pc = ^bus.pc;
   assign upd_ctr   = table_q[bus.upd_idx];

   // Saturating step of the counter being trained
   always_comb begin
      upd_next = upd_ctr;
      if (bus.taken) begin
         if (upd_ctr != CTR_MAX) upd_next = upd_ctr + CTR_W'(1);
      end else begin
         if (upd_ctr != '0) upd_next = upd_ctr - CTR_W'(1);
      end
   end

   // Counter storage: init sweep or training write, never both
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         table_q[ptr] <= WNT;
      end else if (bus.result) begin
         table_q[bus.upd_idx] <= upd_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= INIT;
         ptr          <= '0;
         ready_q      <= 1'b0;
         pred_valid_q <= 1'b0;
         prediction_q <= 1'b0;
         pred_idx_q   <= '0;
         ghr_q        <= '0;
         mis_q        <= '0;
      end else begin
         pred_valid_q <= 1'b0;
         case (state)
            INIT: begin
               ptr <= ptr + IDX_W'(1);
               if (ptr == IDX_W'(DEPTH - 1)) begin
                  state   <= RUN;
                  ready_q <= 1'b1;
               end
            end
            RUN: begin
               // Reads see pre-update table and history, giving read-before-write
               if (bus.request) begin
                  pred_valid_q <= 1'b1;
                  pred_idx_q   <= idx;
                  prediction_q <= table_q[idx][CTR_W-1];
               end
               if (bus.result) begin
                  ghr_q <= HIST_W'({ghr_q, bus.taken});
                  if ((bus.taken != bus.upd_pred) && !(&mis_q)) mis_q <= mis_q + CNT_W'(1);
               end
            end
            default: state <= INIT;
         endcase
      end
   end

   assign bus.ready       = ready_q;
   assign bus.pred_valid  = pred_valid_q;
   assign bus.prediction  = prediction_q;
   assign bus.pred_idx    = pred_idx_q;
   assign bus.ghr         = ghr_q;
   assign bus.mispredicts = mis_q;

endmodule
